// File: rtl/multi_lane_fifo_pkg.sv
// Shared helpers for the multi-lane staging FIFO: pointer width, lane
// slice offsets and the default almost-full threshold.
package multi_lane_fifo_pkg;

  // Pointer/count width: index bits plus one wrap bit.
  function automatic int cw_of(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Low bit of lane k inside a flattened LANES*w vector.
  function automatic int lane_lo(input int k, input int w);
    return k * w;
  endfunction

  // Almost-full leaves a few entries of headroom for in-flight writes.
  function automatic int af_default(input int depth);
    return depth - 4;
  endfunction

endpackage

// File: rtl/multi_lane_fifo_if.sv
// Bus bundle between the PE-array writer / SRAM writeback reader and the
// multi-lane FIFO.
//
// Handshake: lane k accepts i_write[k] on a rising edge only when o_full[k]
// is low at the start of that cycle; a write to a full lane is dropped and
// flagged in o_ovf. i_read pops every lane on a rising edge only when
// o_valid is high (all lanes non-empty); otherwise nothing moves and o_udf
// is flagged. o_data shows the head words whenever o_valid is high.
interface multi_lane_fifo_if #(
  parameter int LANES = 8,
  parameter int WIDTH = 32,
  parameter int CW    = 7
);
  logic                   i_clear;
  logic [LANES-1:0]       i_write;
  logic [LANES*WIDTH-1:0] i_data;
  logic                   i_read;
  logic [LANES*WIDTH-1:0] o_data;
  logic                   o_valid;
  logic [LANES-1:0]       o_full;
  logic [LANES-1:0]       o_empty;
  logic                   o_almost_full;
  logic [LANES*CW-1:0]    o_count;
  logic                   o_ovf;
  logic                   o_udf;

  modport master (
    output i_clear, i_write, i_data, i_read,
    input  o_data, o_valid, o_full, o_empty, o_almost_full, o_count, o_ovf, o_udf
  );

  modport slave (
    input  i_clear, i_write, i_data, i_read,
    output o_data, o_valid, o_full, o_empty, o_almost_full, o_count, o_ovf, o_udf
  );
endinterface

// File: rtl/multi_lane_fifo_lane.sv
// One FIFO lane: storage, wrap-bit pointers and pointer-derived flags.
// Pop is driven from outside and is assumed legal (lane non-empty).
module multi_lane_fifo_lane
  import multi_lane_fifo_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int WIDTH = 32,
  localparam int CW   = cw_of(DEPTH),
  localparam int AW   = CW - 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    wptr;
  logic [CW-1:0]    rptr;
  logic             push_ok;

  // Full is judged on the start-of-cycle pointers, so a same-cycle pop
  // never rescues a write to a full lane.
  assign push_ok = push && !full;
  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[CW-1] != rptr[CW-1]);
  assign count   = wptr - rptr;
  assign rdata   = mem[rptr[AW-1:0]];

  // Pointer update; clear overrides any concurrent push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else if (clear) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop)     rptr <= rptr + 1'b1;
    end
  end

  // Storage write; contents are not reset, only the pointers are.
  always_ff @(posedge clk) begin
    if (push_ok && !clear) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/multi_lane_fifo.sv
// Bank of LANES independent write lanes popped together by one read.
// Staging buffer between the PE array and SRAM writeback.
module multi_lane_fifo
  import multi_lane_fifo_pkg::*;
#(
  parameter int DEPTH    = 64,
  parameter int WIDTH    = 32,
  parameter int LANES    = 8,
  parameter int AF_LEVEL = af_default(DEPTH)
) (
  input logic               clk,
  input logic               rst_n,
  multi_lane_fifo_if.slave  bus
);

  localparam int CW = cw_of(DEPTH);

  logic [LANES-1:0]       full;
  logic [LANES-1:0]       empty;
  logic [LANES-1:0]       af_hit;
  logic [LANES*WIDTH-1:0] head;
  logic [LANES*CW-1:0]    count;
  logic                   valid;
  logic                   pop;
  logic                   ovf_q;
  logic                   udf_q;

  // A pop is only legal when every lane has a word, so partial pops never occur.
  assign valid = ~|empty;
  assign pop   = bus.i_read && valid;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    multi_lane_fifo_lane #(
      .DEPTH (DEPTH),
      .WIDTH (WIDTH)
    ) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (bus.i_clear),
      .push  (bus.i_write[k]),
      .pop   (pop),
      .wdata (bus.i_data[lane_lo(k, WIDTH) +: WIDTH]),
      .rdata (head[lane_lo(k, WIDTH) +: WIDTH]),
      .full  (full[k]),
      .empty (empty[k]),
      .count (count[lane_lo(k, CW) +: CW])
    );
    assign af_hit[k] = (count[lane_lo(k, CW) +: CW] >= CW'(AF_LEVEL));
  end

  // Sticky error flags: set on illegal access, cleared only by flush or reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else if (bus.i_clear) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (|(bus.i_write & full))   ovf_q <= 1'b1;
      if (bus.i_read && !valid)    udf_q <= 1'b1;
    end
  end

  // Heads are masked so o_data is a clean zero (never stale/X) when not valid.
  assign bus.o_data        = {(LANES*WIDTH){valid}} & head;
  assign bus.o_valid       = valid;
  assign bus.o_full        = full;
  assign bus.o_empty       = empty;
  assign bus.o_almost_full = |af_hit;
  assign bus.o_count       = count;
  assign bus.o_ovf         = ovf_q;
  assign bus.o_udf         = udf_q;

endmodule
